// File: rtl/seg_arb_pkg.sv
// Shared definitions for the seven-segment source arbiter.
package seg_arb_pkg;

  // Width of one display word: four hex digits.
  localparam int unsigned DISP_W = 16;

  // Arbiter FSM: background display or holding a granted event.
  typedef enum logic {
    StIdle,
    StShow
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker. Searches rr_ptr+1 .. rr_ptr with wrap,
// so the most recently granted requester has the lowest priority.
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         pend,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] grant
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest pending one wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = IW'((32'(rr_ptr) + off) % N);
      if (pend[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/seg_source_arbiter.sv
// Shares the seven-segment display between N_REQ one-cycle event sources and a
// background word. Each captured event is held on the display for HOLD_CYCLES;
// pending events are served round-robin, back to back, without a background gap.
module seg_source_arbiter
  import seg_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = DISP_W,
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [DATA_W-1:0]        bg_data,
  output logic [DATA_W-1:0]        disp_data,
  output logic [$clog2(N_REQ)-1:0] disp_src,
  output logic                     disp_bg,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         overrun,
  output logic                     busy
);

  localparam int unsigned SW = $clog2(N_REQ);
  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] pend_data_q [N_REQ];
  logic [DATA_W-1:0] pend_data_d [N_REQ];
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [SW-1:0]     disp_src_q, disp_src_d;
  logic              disp_bg_q, disp_bg_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  overrun_q, overrun_d;

  logic              pick_any;
  logic [SW-1:0]     pick_idx;
  logic              grant_now;
  logic [N_REQ-1:0]  clear;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .pend   (pend_q),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .grant  (pick_idx)
  );

  // Next-state: FSM, hold counter, grant bookkeeping and event capture.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    disp_data_d = disp_data_q;
    disp_src_d  = disp_src_q;
    disp_bg_d   = disp_bg_q;
    ack_d       = '0;
    clear       = '0;
    grant_now   = 1'b0;
    pend_data_d = pend_data_q;

    unique case (state_q)
      StIdle: begin
        disp_data_d = bg_data;
        disp_bg_d   = 1'b1;
        grant_now   = pick_any;
      end
      StShow: begin
        hold_cnt_d = hold_cnt_q + HW'(1);
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          if (pick_any) begin
            grant_now = 1'b1;
          end else begin
            state_d     = StIdle;
            hold_cnt_d  = '0;
            disp_data_d = bg_data;
            disp_bg_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The slot register still holds the old word here, so a same-cycle
    // re-capture is displayed later rather than replacing this grant.
    if (grant_now) begin
      state_d          = StShow;
      disp_data_d      = pend_data_q[pick_idx];
      disp_src_d       = pick_idx;
      disp_bg_d        = 1'b0;
      ack_d[pick_idx]  = 1'b1;
      clear[pick_idx]  = 1'b1;
      rr_ptr_d         = pick_idx;
      hold_cnt_d       = '0;
    end

    // A new pulse beats the grant's clear on the same requester.
    pend_d    = (pend_q & ~clear) | req;
    overrun_d = overrun_q | (req & pend_q);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        pend_data_d[i] = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State registers with synchronous reset; pending events are dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= SW'(N_REQ - 1);
      disp_data_q <= '0;
      disp_src_q  <= '0;
      disp_bg_q   <= 1'b1;
      ack_q       <= '0;
      overrun_q   <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        pend_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_cnt_q  <= hold_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      disp_data_q <= disp_data_d;
      disp_src_q  <= disp_src_d;
      disp_bg_q   <= disp_bg_d;
      ack_q       <= ack_d;
      overrun_q   <= overrun_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_src  = disp_src_q;
  assign disp_bg   = disp_bg_q;
  assign ack       = ack_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StShow);

endmodule

// File: tb/tb_seg_source_arbiter.sv
// Self-checking bench for seg_source_arbiter: directed scenarios plus random
// traffic, compared every cycle against an event-level reference model.
module tb_seg_source_arbiter;

  localparam int N    = 3;
  localparam int DW   = 16;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] bg_data;
  logic [DW-1:0] disp_data;
  logic [1:0]    disp_src;
  logic          disp_bg;
  logic [N-1:0]  ack;
  logic [N-1:0]  overrun;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  seg_source_arbiter #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .bg_data   (bg_data),
    .disp_data (disp_data),
    .disp_src  (disp_src),
    .disp_bg   (disp_bg),
    .ack       (ack),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending flags/words per requester, the word on display
  // with the number of cycles it still has to stay, and the last one served.
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_data [N];
  bit            m_show;
  int            m_left;
  int            m_last;
  logic [DW-1:0] e_disp;
  int            e_src;
  logic          e_bg;
  logic [N-1:0]  e_ack;
  logic [N-1:0]  e_ovr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick();
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (m_last + off) % N;
      if (m_pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*DW-1:0] rd,
                            input logic [DW-1:0] bg);
    logic [N-1:0] old_pend;
    int k;
    if (r) begin
      m_pend = '0;
      m_show = 0;
      m_left = 0;
      m_last = N - 1;
      e_disp = '0;
      e_src  = 0;
      e_bg   = 1'b1;
      e_ack  = '0;
      e_ovr  = '0;
      return;
    end
    old_pend = m_pend;
    e_ack    = '0;
    k        = -1;
    if (!m_show) begin
      e_disp = bg;
      e_bg   = 1'b1;
      k      = m_pick();
    end else if (m_left == 1) begin
      k = m_pick();
      if (k < 0) begin
        m_show = 0;
        e_disp = bg;
        e_bg   = 1'b1;
      end
    end else begin
      m_left--;
    end
    if (k >= 0) begin
      e_disp    = m_data[k];
      e_src     = k;
      e_bg      = 1'b0;
      e_ack[k]  = 1'b1;
      m_pend[k] = 1'b0;
      m_last    = k;
      m_left    = HOLD;
      m_show    = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i]) begin
        if (old_pend[i]) e_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_data[i] = rd[i*DW +: DW];
      end
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, sample 1 ns later.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*DW-1:0] rd,
                      input logic [DW-1:0] bg);
    @(negedge clk);
    reset    = r;
    req      = rq;
    req_data = rd;
    bg_data  = bg;
    @(posedge clk);
    model_edge(r, rq, rd, bg);
    #1;
    chk("disp_data", 64'(disp_data), 64'(e_disp));
    chk("disp_src",  64'(disp_src),  64'(e_src));
    chk("disp_bg",   64'(disp_bg),   64'(e_bg));
    chk("ack",       64'(ack),       64'(e_ack));
    chk("overrun",   64'(overrun),   64'(e_ovr));
    chk("busy",      64'(busy),      64'(m_show));
  endtask

  task automatic idle(input int n, input logic [DW-1:0] bg);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, bg);
  endtask

  initial begin
    logic [DW-1:0] bg;
    int guard;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    bg_data  = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;

    // Reset held for two cycles.
    step(1'b1, '0, '0, 16'h0000);
    step(1'b1, '0, '0, 16'h0000);
    chk("reset_bg", 64'(disp_bg), 64'd1);
    chk("reset_data", 64'(disp_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // Single event on requester 1 over a background word.
    bg = 16'h0F0F;
    idle(3, bg);
    step(1'b0, 3'b010, {16'h0, 16'h0041, 16'h0}, bg);
    step(1'b0, '0, '0, bg);
    chk("single_latency", 64'(disp_data), 64'h0041);
    chk("single_ack", 64'(ack), 64'b010);
    idle(12, bg);
    chk("single_back_bg", 64'(disp_data), 64'h0F0F);

    // Three simultaneous events, served in round-robin order.
    step(1'b0, 3'b111, {16'hCCCC, 16'hBBBB, 16'hAAAA}, bg);
    idle(3 * HOLD + 4, bg);

    // Requester 0 pulses every cycle while requester 2 is also waiting.
    step(1'b0, 3'b101, {16'h2222, 16'h0, 16'h1000}, bg);
    for (int i = 1; i < 4 * HOLD; i++) begin
      step(1'b0, 3'b001, {32'h0, 16'(16'h1000 + i)}, bg);
    end
    idle(3 * HOLD, bg);

    // Re-capture of requester 2 on the very edge its pending flag is cleared.
    step(1'b0, 3'b010, {16'h0, 16'h1111, 16'h0}, bg);
    step(1'b0, 3'b100, {16'h2A2A, 32'h0}, bg);
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (m_show && m_left == 1 && m_pick() == 2)
        step(1'b0, 3'b100, {16'hC0DE, 32'h0}, bg);
      else
        step(1'b0, '0, '0, bg);
    end
    idle(2 * HOLD, bg);

    // Reset in the middle of a hold while requester 0 is pending.
    step(1'b0, 3'b010, {16'h0, 16'h5151, 16'h0}, bg);
    step(1'b0, 3'b001, {32'h0, 16'h0A0A}, bg);
    guard = 0;
    while (m_left != HOLD - 4 && guard < 20) begin
      step(1'b0, '0, '0, bg);
      guard++;
    end
    chk("midshow_reached", 64'(guard < 20), 64'd1);
    step(1'b1, '0, '0, bg);
    chk("midshow_reset_bg", 64'(disp_bg), 64'd1);
    for (int i = 0; i < 2 * HOLD; i++) begin
      step(1'b0, '0, '0, bg);
      chk("midshow_no_ack0", 64'(ack[0]), 64'd0);
    end

    // Random traffic with occasional background changes and resets.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0]    rq;
      logic [N*DW-1:0] rd;
      logic            r;
      for (int i = 0; i < N; i++) begin
        rq[i] = ($urandom_range(0, 5) == 0);
        rd[i*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bg = DW'($urandom);
      r = ($urandom_range(0, 299) == 0);
      step(r, rq, rd, bg);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
